uart_tx_engine: RTL

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

---
 rtl/apb_uart_pkg.sv | 28 ++
 rtl/uart_baud_tick.sv | 44 ++++
 rtl/uart_tx_engine.sv | 136 +++++++++++++
 3 files changed

// File: rtl/apb_uart_pkg.sv
// rtl/apb_uart_pkg.sv - shared UART types: frame config fields and TX FSM states
//
// Purpose: common widths, the cfg_reg_t field set and the TX engine state enum,
//          shared by the TX engine, the baud tick counter and the RX engine.
// Ports:   none (package)

package apb_uart_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DIV_W  = 32;

  // Frame configuration fields as held in the CFG register.
  typedef struct packed {
    logic extra_stop_bits;  // 1 = two stop bits
    logic parity_type;      // 0 = even, 1 = odd
    logic parity_en;
  } cfg_reg_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } tx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period down-counter producing one tick per bit
//
// Purpose: holds a latched divider and counts it down while enabled; tick is
//          high on the last cycle of each bit period (div+1 enabled cycles).
// Ports:   clk   - clock
//          rst_n - asynchronous active-low reset
//          load  - latch div and restart the period
//          div   - bit period minus one
//          en    - count enable; when low the counter is frozen
//          tick  - last enabled cycle of the current bit period

module uart_baud_tick
  import apb_uart_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  input  logic             en,
  output logic             tick
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;

  // Counting down to zero and reloading avoids computing div+1, so the
  // all-ones divider cannot overflow.
  assign tick = en && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      cnt   <= '0;
    end else if (load) begin
      div_q <= div;
      cnt   <= div;
    end else if (tick) begin
      cnt   <= div_q;
    end else if (en) begin
      cnt   <= cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - UART transmit engine: pops a byte and serialises a frame
//
// Purpose: start bit, 8 data bits LSB first, optional parity, one or two stop
//          bits. Divider and config are latched per frame at the FIFO pop.
// Ports:   clk_i          - clock
//          arst_ni        - asynchronous active-low reset
//          clk_en_i       - UART enable; low freezes a frame in progress
//          clk_div_i      - bit period minus one
//          parity_en_i    - parity bit enable
//          parity_type_i  - 0 = even, 1 = odd
//          extra_stop_i   - 1 = two stop bits
//          data_i         - byte at the TX FIFO head
//          data_valid_i   - TX FIFO not empty
//          data_ready_o   - TX FIFO pop strobe
//          tx_o           - serial line, idle high
//          busy_o         - frame in progress

module uart_tx_engine
  import apb_uart_pkg::*;
(
  input  logic              clk_i,
  input  logic              arst_ni,
  input  logic              clk_en_i,
  input  logic [DIV_W-1:0]  clk_div_i,
  input  logic              parity_en_i,
  input  logic              parity_type_i,
  input  logic              extra_stop_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              data_valid_i,
  output logic              data_ready_o,
  output logic              tx_o,
  output logic              busy_o
);

  tx_state_e         state;
  logic [DATA_W-1:0] data_q;
  cfg_reg_t          cfg_q;
  logic [2:0]        bit_idx;
  logic              handshake;
  logic              baud_en;
  logic              tick;

  // Gated by reset so no pop can be advertised while reset is held.
  assign data_ready_o = arst_ni && clk_en_i && (state == IDLE);
  assign handshake    = data_valid_i && data_ready_o;
  assign baud_en      = clk_en_i && (state != IDLE);

  uart_baud_tick u_baud_tick (
    .clk   (clk_i),
    .rst_n (arst_ni),
    .load  (handshake),
    .div   (clk_div_i),
    .en    (baud_en),
    .tick  (tick)
  );

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state   <= IDLE;
      data_q  <= '0;
      cfg_q   <= '0;
      bit_idx <= '0;
      tx_o    <= 1'b1;
      busy_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            data_q                <= data_i;
            cfg_q.parity_en       <= parity_en_i;
            cfg_q.parity_type     <= parity_type_i;
            cfg_q.extra_stop_bits <= extra_stop_i;
            bit_idx               <= '0;
            tx_o                  <= 1'b0;
            busy_o                <= 1'b1;
            state                 <= START;
          end
        end
        START: begin
          if (tick) begin
            tx_o  <= data_q[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            // Index wraps 7 -> 0, leaving it ready for the next frame.
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              if (cfg_q.parity_en) begin
                // Even: XOR of data bits; odd: XNOR.
                tx_o  <= (^data_q) ^ cfg_q.parity_type;
                state <= PARITY;
              end else begin
                tx_o  <= 1'b1;
                state <= STOP1;
              end
            end else begin
              tx_o <= data_q[bit_idx + 3'd1];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            tx_o  <= 1'b1;
            state <= STOP1;
          end
        end
        STOP1: begin
          if (tick) begin
            tx_o <= 1'b1;
            if (cfg_q.extra_stop_bits) begin
              state <= STOP2;
            end else begin
              busy_o <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        STOP2: begin
          if (tick) begin
            tx_o   <= 1'b1;
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          tx_o   <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
